// File: rtl/sample_trigger_bank_pkg.sv
// Shared definitions for the sample trigger bank.
// Holds the per-channel IDLE/PLAY state encoding and the playback mode constants
// used by sample_channel and sample_trigger_bank.
package sample_trigger_bank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } ch_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_LOOP    = 1'b1;

endpackage

// File: rtl/sample_trigger_bank_channel.sv
// sample_channel: one playback channel (FSM, address counter, capture registers).
// Ports:
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   start         : valid trigger aimed at this channel (restart from address 0)
//   kill          : stop or exclusive kill; return to IDLE without a done pulse
//   mode, len     : playback mode and length, captured when start is high
//   tick          : sample-rate enable
//   restart       : one-cycle pulse after a (re)start
//   done          : one-cycle pulse when a one-shot playback completes
//   addr          : current sample address (0 whenever IDLE)
//   state         : current FSM state, also used as the playing indication
//
// Handshake: there is no back-pressure. start/kill/tick are single-cycle
// qualifiers sampled at the rising edge; all outputs change one cycle later.
module sample_channel
    import sample_trigger_bank_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              kill,
    input  logic              mode,
    input  logic [ADDR_W-1:0] len,
    input  logic              tick,
    output logic              restart,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output ch_state_t         state
);

    ch_state_t         state_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [ADDR_W-1:0] len_q, len_nx;
    logic              mode_q, mode_nx;
    logic              restart_nx;
    logic              done_nx;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            addr    <= '0;
            len_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            restart <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            addr    <= addr_nx;
            len_q   <= len_nx;
            mode_q  <= mode_nx;
            restart <= restart_nx;
            done    <= done_nx;
        end
    end

    // Priority: start beats kill beats tick. A start in the same cycle as a
    // tick loads address 0 rather than advancing.
    always_comb begin
        state_nx   = state;
        addr_nx    = addr;
        len_nx     = len_q;
        mode_nx    = mode_q;
        restart_nx = 1'b0;
        done_nx    = 1'b0;
        if (start) begin
            state_nx   = ST_PLAY;
            addr_nx    = '0;
            len_nx     = len;
            mode_nx    = mode;
            restart_nx = 1'b1;
        end else if (kill) begin
            state_nx = ST_IDLE;
            addr_nx  = '0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (tick) begin
                        // len_q is never 0 in PLAY, so len_q-1 does not wrap.
                        if (addr == len_q - ADDR_W'(1)) begin
                            addr_nx = '0;
                            if (mode_q == MODE_ONESHOT) begin
                                state_nx = ST_IDLE;
                                done_nx  = 1'b1;
                            end
                        end else begin
                            addr_nx = addr + ADDR_W'(1);
                        end
                    end
                end
                default: addr_nx = '0;
            endcase
        end
    end

endmodule

// File: rtl/sample_trigger_bank.sv
// sample_trigger_bank: bank of NUM_CH sample playback channels.
// Decodes trig/stop against code, applies the EXCLUSIVE kill and concatenates
// the per-channel outputs.
// Ports:
//   clock, resetn      : rising-edge clock, synchronous active-low reset
//   trig, stop, code   : one-cycle strobes and their target channel
//   mode, len          : captured on a valid trig (len == 0 is ignored)
//   tick               : sample-rate enable
//   ch_en              : channel i is playing
//   ch_reset, ch_done  : one-cycle restart / one-shot completion pulses
//   ch_addr            : channel i address at [i*ADDR_W +: ADDR_W]
module sample_trigger_bank
    import sample_trigger_bank_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CODE_W    = 2,
    parameter int ADDR_W    = 16,
    parameter int EXCLUSIVE = 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     trig,
    input  logic                     stop,
    input  logic [CODE_W-1:0]        code,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        len,
    input  logic                     tick,
    output logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH-1:0]        ch_reset,
    output logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_done
);

    logic code_ok;
    logic trig_ok;
    logic stop_ok;

    assign code_ok = (int'(code) < NUM_CH);
    assign trig_ok = trig && code_ok && (len != '0);
    // Any trig in the same cycle suppresses stop.
    assign stop_ok = stop && !trig && code_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic      hit;
        logic      start;
        logic      kill;
        ch_state_t state;

        assign hit   = (code == CODE_W'(i));
        assign start = trig_ok && hit;
        assign kill  = (stop_ok && hit) ||
                       ((EXCLUSIVE != 0) && trig_ok && !hit);

        sample_channel #(
            .ADDR_W (ADDR_W)
        ) u_ch (
            .clock   (clock),
            .resetn  (resetn),
            .start   (start),
            .kill    (kill),
            .mode    (mode),
            .len     (len),
            .tick    (tick),
            .restart (ch_reset[i]),
            .done    (ch_done[i]),
            .addr    (ch_addr[i*ADDR_W +: ADDR_W]),
            .state   (state)
        );

        assign ch_en[i] = (state == ST_PLAY);
    end

endmodule

// File: tb/tb_sample_trigger_bank.sv
// Directed bench for sample_trigger_bank: instance A is exclusive (NUM_CH=4,
// CODE_W=2), instance B is non-exclusive with a 3-bit code so out-of-range
// codes can be driven.
module tb_sample_trigger_bank;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] len = '0;
    logic        tick = 1'b0;

    logic        trig_a = 1'b0, stop_a = 1'b0;
    logic [1:0]  code_a = '0;
    logic [3:0]  en_a, rst_a, done_a;
    logic [63:0] addr_a;

    logic        trig_b = 1'b0, stop_b = 1'b0;
    logic [2:0]  code_b = '0;
    logic [3:0]  en_b, rst_b, done_b;
    logic [63:0] addr_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    sample_trigger_bank #(.NUM_CH(4), .CODE_W(2), .ADDR_W(16), .EXCLUSIVE(1)) dut_a (
        .clock(clock), .resetn(resetn), .trig(trig_a), .stop(stop_a), .code(code_a),
        .mode(mode), .len(len), .tick(tick), .ch_en(en_a), .ch_reset(rst_a),
        .ch_addr(addr_a), .ch_done(done_a)
    );

    sample_trigger_bank #(.NUM_CH(4), .CODE_W(3), .ADDR_W(16), .EXCLUSIVE(0)) dut_b (
        .clock(clock), .resetn(resetn), .trig(trig_b), .stop(stop_b), .code(code_b),
        .mode(mode), .len(len), .tick(tick), .ch_en(en_b), .ch_reset(rst_b),
        .ch_addr(addr_b), .ch_done(done_b)
    );

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] en, input logic [3:0] rs,
                         input logic [3:0] dn, input logic [63:0] ad);
        chk({tag, ".a.en"},   64'(en_a),   64'(en));
        chk({tag, ".a.rst"},  64'(rst_a),  64'(rs));
        chk({tag, ".a.done"}, 64'(done_a), 64'(dn));
        chk({tag, ".a.addr"}, addr_a,      ad);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] en, input logic [3:0] rs,
                         input logic [3:0] dn, input logic [63:0] ad);
        chk({tag, ".b.en"},   64'(en_b),   64'(en));
        chk({tag, ".b.rst"},  64'(rst_b),  64'(rs));
        chk({tag, ".b.done"}, 64'(done_b), 64'(dn));
        chk({tag, ".b.addr"}, addr_b,      ad);
    endtask

    initial begin
        // reset
        resetn = 1'b0;
        cyc();
        cyc();
        chk_a("reset", 4'b0000, 4'b0000, 4'b0000, 64'h0);
        chk_b("reset", 4'b0000, 4'b0000, 4'b0000, 64'h0);
        resetn = 1'b1;

        // one-shot, ch2, len 3, tick every cycle (including the trig cycle)
        tick = 1'b1; code_a = 2'd2; len = 16'd3; mode = 1'b0; trig_a = 1'b1;
        cyc();
        trig_a = 1'b0;
        chk_a("os_start", 4'b0100, 4'b0100, 4'b0000, pk(0, 0, 0, 0));
        cyc();
        chk_a("os_a1", 4'b0100, 4'b0000, 4'b0000, pk(0, 0, 1, 0));
        cyc();
        chk_a("os_a2", 4'b0100, 4'b0000, 4'b0000, pk(0, 0, 2, 0));
        cyc();
        chk_a("os_done", 4'b0000, 4'b0000, 4'b0100, pk(0, 0, 0, 0));
        cyc();
        chk_a("os_idle", 4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0));

        // loop, ch1, len 2: addresses 0,1,0,1,0,1
        code_a = 2'd1; len = 16'd2; mode = 1'b1; trig_a = 1'b1;
        cyc();
        trig_a = 1'b0;
        chk_a("loop0", 4'b0010, 4'b0010, 4'b0000, pk(0, 0, 0, 0));
        for (int k = 1; k < 6; k++) begin
            cyc();
            chk_a($sformatf("loop%0d", k), 4'b0010, 4'b0000, 4'b0000, pk(0, k % 2, 0, 0));
        end
        // stop the looping channel: no done pulse
        stop_a = 1'b1;
        cyc();
        stop_a = 1'b0;
        chk_a("loop_stop", 4'b0000, 4'b0000, 4'b0000, 64'h0);

        // exclusive kill: ch0 at addr 5, then trig ch1
        tick = 1'b0; code_a = 2'd0; len = 16'd10; mode = 1'b0; trig_a = 1'b1;
        cyc();
        trig_a = 1'b0; tick = 1'b1;
        repeat (5) cyc();
        tick = 1'b0;
        cyc();
        chk_a("ex_addr5", 4'b0001, 4'b0000, 4'b0000, pk(5, 0, 0, 0));
        code_a = 2'd1; trig_a = 1'b1;
        cyc();
        trig_a = 1'b0;
        chk_a("ex_kill", 4'b0010, 4'b0010, 4'b0000, pk(0, 0, 0, 0));

        // reset mid-playback at ch1 addr 7, with tick and trig during reset
        tick = 1'b1;
        repeat (7) cyc();
        tick = 1'b0;
        chk_a("pre_rst", 4'b0010, 4'b0000, 4'b0000, pk(0, 7, 0, 0));
        resetn = 1'b0; tick = 1'b1; trig_a = 1'b1; code_a = 2'd2; len = 16'd3;
        cyc();
        resetn = 1'b1; trig_a = 1'b0;
        chk_a("in_rst", 4'b0000, 4'b0000, 4'b0000, 64'h0);
        cyc();
        tick = 1'b0;
        chk_a("post_rst", 4'b0000, 4'b0000, 4'b0000, 64'h0);

        // non-exclusive: ch0 and ch3 playing together
        code_b = 3'd0; len = 16'd8; mode = 1'b0; trig_b = 1'b1;
        cyc();
        chk_b("nx_ch0", 4'b0001, 4'b0001, 4'b0000, 64'h0);
        code_b = 3'd3;
        cyc();
        trig_b = 1'b0;
        chk_b("nx_ch3", 4'b1001, 4'b1000, 4'b0000, 64'h0);
        tick = 1'b1;
        repeat (2) cyc();
        tick = 1'b0;
        chk_b("nx_run", 4'b1001, 4'b0000, 4'b0000, pk(2, 0, 0, 2));
        // trig and stop together: trig wins, ch3 untouched
        code_b = 3'd0; trig_b = 1'b1; stop_b = 1'b1;
        cyc();
        trig_b = 1'b0; stop_b = 1'b0;
        chk_b("nx_trig_stop", 4'b1001, 4'b0001, 4'b0000, pk(0, 0, 0, 2));
        code_b = 3'd3; stop_b = 1'b1;
        cyc();
        chk_b("nx_stop3", 4'b0001, 4'b0000, 4'b0000, 64'h0);
        code_b = 3'd2;
        cyc();
        stop_b = 1'b0;
        chk_b("nx_stop_idle", 4'b0001, 4'b0000, 4'b0000, 64'h0);

        // ignored triggers: len 0, then code 5
        code_b = 3'd2; len = 16'd0; trig_b = 1'b1;
        cyc();
        chk_b("ign_len0", 4'b0001, 4'b0000, 4'b0000, 64'h0);
        code_b = 3'd5; len = 16'd3;
        cyc();
        trig_b = 1'b0;
        chk_b("ign_code5", 4'b0001, 4'b0000, 4'b0000, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
